// File: rtl/cell_clear_engine.sv
// Cell-erase engine: latches up to NUM_SEL cell indices and paints each valid,
// distinct cell as a solid CELL_W x CELL_H rectangle, one pixel per clock.
module cell_clear_engine #(
  parameter int unsigned NUM_SEL   = 3,
  parameter int unsigned SEL_W     = 4,
  parameter int unsigned GRID_COLS = 3,
  parameter int unsigned GRID_ROWS = 3,
  parameter int unsigned X_ORIGIN  = 50,
  parameter int unsigned Y_ORIGIN  = 30,
  parameter int unsigned PITCH_X   = 20,
  parameter int unsigned PITCH_Y   = 20,
  parameter int unsigned CELL_W    = 16,
  parameter int unsigned CELL_H    = 16,
  parameter int unsigned COLOUR_W  = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [NUM_SEL*SEL_W-1:0]       sel_in,
  input  logic [COLOUR_W-1:0]            fill_colour,
  input  logic                           clear_mask,
  output logic [7:0]                     xout,
  output logic [6:0]                     yout,
  output logic [COLOUR_W-1:0]            colour,
  output logic                           plot,
  output logic                           busy,
  output logic                           done,
  output logic [GRID_COLS*GRID_ROWS-1:0] cleared_mask
);

  localparam int unsigned NUM_CELLS = GRID_COLS * GRID_ROWS;
  localparam int unsigned SLOT_W    = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;
  localparam int unsigned PX_W      = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int unsigned PY_W      = (CELL_H > 1) ? $clog2(CELL_H) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DRAW, S_ADVANCE, S_DONE} state_t;

  state_t              state;
  logic [SEL_W-1:0]    sel_arr [NUM_SEL];
  logic [COLOUR_W-1:0] colour_q;
  logic [SLOT_W-1:0]   slot;
  logic [PX_W-1:0]     px;
  logic [PY_W-1:0]     py;
  logic [7:0]          x0;
  logic [6:0]          y0;

  logic [SEL_W-1:0]     idx_c;
  logic                 dup_c;
  logic                 skip_c;
  int unsigned          cell_c;
  int unsigned          col_c;
  int unsigned          row_c;
  logic [7:0]           x0_c;
  logic [6:0]           y0_c;
  logic [NUM_CELLS-1:0] one_hot_c;
  logic                 px_last_c;
  logic                 py_last_c;
  logic [PX_W-1:0]      px_n_c;
  logic [PY_W-1:0]      py_n_c;

  // Decode of the current slot: validity, duplicate filter and cell origin
  always_comb begin
    idx_c = sel_arr[slot];
    dup_c = 1'b0;
    for (int k = 0; k < NUM_SEL; k++) begin
      if ((SLOT_W'(k) < slot) && (sel_arr[k] == idx_c)) dup_c = 1'b1;
    end
    skip_c    = (idx_c == '0) || (32'(idx_c) > NUM_CELLS) || dup_c;
    cell_c    = 32'(idx_c) - 32'd1;
    col_c     = cell_c % GRID_COLS;
    row_c     = cell_c / GRID_COLS;
    x0_c      = 8'(X_ORIGIN + col_c * PITCH_X);
    y0_c      = 7'(Y_ORIGIN + row_c * PITCH_Y);
    one_hot_c = {{(NUM_CELLS-1){1'b0}}, 1'b1} << cell_c;
  end

  // Raster-scan step within the rectangle
  always_comb begin
    px_last_c = (px == PX_W'(CELL_W - 1));
    py_last_c = (py == PY_W'(CELL_H - 1));
    px_n_c    = px_last_c ? '0 : px + PX_W'(1);
    py_n_c    = px_last_c ? py + PY_W'(1) : py;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      colour_q     <= '0;
      slot         <= '0;
      px           <= '0;
      py           <= '0;
      x0           <= '0;
      y0           <= '0;
      xout         <= '0;
      yout         <= '0;
      colour       <= '0;
      plot         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cleared_mask <= '0;
      for (int k = 0; k < NUM_SEL; k++) sel_arr[k] <= '0;
    end else begin
      done <= 1'b0;
      // A clear coinciding with a CHECK leaves only the freshly painted bit
      cleared_mask <= (clear_mask ? '0 : cleared_mask)
                    | (((state == S_CHECK) && !skip_c) ? one_hot_c : '0);
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < NUM_SEL; k++) sel_arr[k] <= sel_in[k*SEL_W +: SEL_W];
            colour_q <= fill_colour;
            slot     <= '0;
            busy     <= 1'b1;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (skip_c) begin
            state <= S_ADVANCE;
          end else begin
            x0     <= x0_c;
            y0     <= y0_c;
            px     <= '0;
            py     <= '0;
            xout   <= x0_c;
            yout   <= y0_c;
            colour <= colour_q;
            plot   <= 1'b1;
            state  <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (px_last_c && py_last_c) begin
            plot   <= 1'b0;
            xout   <= '0;
            yout   <= '0;
            colour <= '0;
            state  <= S_ADVANCE;
          end else begin
            px   <= px_n_c;
            py   <= py_n_c;
            xout <= x0 + 8'(px_n_c);
            yout <= y0 + 7'(py_n_c);
          end
        end
        S_ADVANCE: begin
          if (slot == SLOT_W'(NUM_SEL - 1)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            slot  <= slot + SLOT_W'(1);
            state <= S_CHECK;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
